// File: rtl/fsm_operand_feeder.sv
// fsm_operand_feeder: buffers operand pairs and feeds them to the encode/ALU engine one job at a time
module fsm_operand_feeder #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_a,
  input  logic [DATA_W-1:0]          in_b,
  output logic                       start,
  output logic [DATA_W-1:0]          op_data,
  input  logic                       eng_done,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     level,
  output logic [7:0]                 jobs_done,
  output logic                       err_timeout
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {F_IDLE, F_START, F_SEND_A, F_SEND_B, F_WAIT} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [LW-1:0]     level_q;
  logic [WW-1:0]     wd_q;
  logic [7:0]        jobs_q;
  logic              err_q;
  logic              push, pop, done_ok, wd_hit;
  assign in_ready    = level_q != LW'(DEPTH);
  assign push        = in_valid && in_ready;
  assign pop         = state_q == F_SEND_B;
  assign done_ok     = state_q == F_WAIT && eng_done;
  assign wd_hit      = state_q == F_WAIT && !eng_done && wd_q == WW'(TIMEOUT - 1);
  assign start       = state_q == F_START;
  assign busy        = state_q != F_IDLE;
  assign level       = level_q;
  assign jobs_done   = jobs_q;
  assign err_timeout = err_q;
  assign op_data     = state_q == F_SEND_A ? mem_a[rd_q] :
                       state_q == F_SEND_B ? mem_b[rd_q] : '0;
  // next-state: one job per queued pair; done beats the watchdog in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      F_IDLE:   state_d = level_q != '0 ? F_START : F_IDLE;
      F_START:  state_d = F_SEND_A;
      F_SEND_A: state_d = F_SEND_B;
      F_SEND_B: state_d = F_WAIT;
      F_WAIT:   state_d = eng_done ? (level_q != '0 ? F_START : F_IDLE) :
                          wd_hit ? F_IDLE : F_WAIT;
      default:  state_d = F_IDLE;
    endcase
  end
  // state, FIFO pointers, watchdog and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= F_IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      wd_q    <= '0;
      jobs_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= push ? wr_q + AW'(1) : wr_q;
      rd_q    <= pop ? rd_q + AW'(1) : rd_q;
      level_q <= level_q + LW'(push) - LW'(pop);
      wd_q    <= state_q == F_WAIT ? wd_q + WW'(1) : '0;
      jobs_q  <= jobs_q + 8'(done_ok);
      err_q   <= wd_hit;
    end
  end
  // pair storage needs no reset; pointers and level define what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_q] <= in_a;
      mem_b[wr_q] <= in_b;
    end
  end
endmodule
